line_cmd_scheduler: RTL and testbench
=====================================

LINE_CMD_SCHEDULER -- requirements
Module: line_cmd_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of line-command requesters (2..8).
REQ-002 SHALL have parameter COORD_W, default 8: coordinate width in bits.
REQ-003 SHALL have parameter COLOR_W, default 4: pixel colour width.
REQ-004 SHALL have port ACLK, input, 1: the only clock, rising edge.
REQ-005 SHALL have port ARESET, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have port REQ_VALID, input, NUM_REQ: per-requester command valid.
REQ-007 SHALL have port REQ_READY, output, NUM_REQ: per-requester command accepted (one-hot or zero).
REQ-008 SHALL have port REQ_CMD, input, NUM_REQ*(4*COORD_W+COLOR_W): per-requester {X0,Y0,X1,Y1,COLOR}, requester 0 in the LSBs.
REQ-009 SHALL have port PIX_VALID, input-side sink handshake, output, 1: pixel available.
REQ-010 SHALL have port PIX_READY, input, 1: sink accepts pixel.
REQ-011 SHALL have ports PIX_X and PIX_Y, output, COORD_W each, and PIX_COLOR, output, COLOR_W: pixel data.
REQ-012 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-013 SHALL have ports DONE, output, 1, and DONE_ID, output, clog2(NUM_REQ): completion pulse and owning requester.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> DRAW -> DONE -> IDLE.
REQ-015 IDLE: when any REQ_VALID bit is high, SHALL assert REQ_READY for exactly one winner that same cycle (combinational) and latch its command; next state LOAD.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on acceptance.
REQ-017 LOAD: SHALL compute dx=X1-X0, dy=Y1-Y0 as signed COORD_W+1-bit values, step signs, magnitudes, and major axis (x-major when |dx|>|dy|, else y-major); error=major/2 in a signed COORD_W+2-bit register; no wrap for any endpoint pair.
REQ-018 DRAW: PIX_VALID SHALL be high; each cycle with PIX_VALID&&PIX_READY SHALL advance one Bresenham step.
REQ-019 PIX_X/PIX_Y/PIX_COLOR SHALL be stable while PIX_VALID&&!PIX_READY.
REQ-020 A line SHALL emit exactly max(|dx|,|dy|)+1 pixels, first (X0,Y0), last (X1,Y1); X0=X1,Y0=Y1 emits one pixel.
REQ-021 Acceptance of the last pixel SHALL move to DONE; DONE asserts DONE=1 and DONE_ID for exactly one cycle, then IDLE.
REQ-022 Latency: command accepted in cycle N -> first PIX_VALID in cycle N+2; with PIX_READY held high, DONE in cycle N+2+pixels.
REQ-023 REQ_READY SHALL be zero in LOAD, DRAW and DONE; requests are next arbitrated in the IDLE cycle after DONE.
REQ-024 Changes on REQ_CMD after acceptance SHALL NOT affect the line in progress.

Reset
REQ-025 ARESET high SHALL force IDLE immediately, including mid-line; any partial line is discarded with no DONE.
REQ-026 Reset values: REQ_READY=0, PIX_VALID=0, PIX_X=PIX_Y=0, PIX_COLOR=0, BUSY=0, DONE=0, DONE_ID=0, last_grant=NUM_REQ-1 (requester 0 wins first).

Configuration
REQ-027 Macro LINE_SCHED_ABORT_EN defined: SHALL add input ABORT (1 bit); ABORT high in LOAD or DRAW SHALL drop PIX_VALID next cycle and enter DONE (DONE pulse with owning DONE_ID).
REQ-028 Macro LINE_SCHED_ABORT_EN undefined: no ABORT port; every accepted line runs to completion.

Structure
REQ-029 Package line_sched_pkg SHALL hold the FSM state enum, command field offsets, and the signed delta/error width constants.
REQ-030 Bresenham stepping (LOAD setup + per-step update) SHALL be a sub-module line_stepper with load/step inputs and x/y/last outputs; arbiter and FSM stay in the top.

Verification
REQ-031 Req0 (10,10)->(13,11), PIX_READY=1 -> pixels (10,10),(11,10),(12,11),(13,11); DONE at N+6, DONE_ID=0.
REQ-032 Req0 and req1 valid together, both held -> order 0,1,0,1; each REQ_READY one cycle.
REQ-033 (255,0)->(0,255) -> 256 pixels, last (0,255), no wrap.
REQ-034 (5,5)->(5,5) -> one pixel (5,5), DONE next cycle.
REQ-035 PIX_READY toggled 1-0-1 during a line -> pixel data held while stalled, no pixel lost or duplicated.
REQ-036 ARESET pulsed mid-line (and, with LINE_SCHED_ABORT_EN, ABORT pulsed) -> IDLE and reset outputs; ABORT yields one DONE.

Source files
------------

// File: rtl/line_sched_pkg.sv
// Shared types and constants for the line command scheduler: FSM states,
// command field offsets and the signed delta/error width extensions.
package line_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Deltas need one extra bit for sign; the error term needs two so it never wraps.
  localparam int unsigned DELTA_EXTRA_W = 1;
  localparam int unsigned ERR_EXTRA_W   = 2;

  // Command layout is {X0,Y0,X1,Y1,COLOR}; COLOR sits at bit 0.
  localparam int unsigned FLD_Y1 = 0;
  localparam int unsigned FLD_X1 = 1;
  localparam int unsigned FLD_Y0 = 2;
  localparam int unsigned FLD_X0 = 3;

  function automatic int unsigned cmd_w(input int unsigned coord_w, input int unsigned color_w);
    return 4 * coord_w + color_w;
  endfunction

  function automatic int unsigned field_off(input int unsigned fld, input int unsigned coord_w,
                                            input int unsigned color_w);
    return color_w + fld * coord_w;
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham line stepper: i_load captures endpoints and sets up deltas/error,
// each i_step advances one pixel along the major axis.
module line_stepper
  import line_sched_pkg::*;
#(
  parameter int unsigned COORD_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_last
);
  localparam int unsigned DW = COORD_W + DELTA_EXTRA_W;
  localparam int unsigned EW = COORD_W + ERR_EXTRA_W;

  logic signed [DW-1:0] w_dx, w_dy;
  logic [COORD_W-1:0]   w_adx, w_ady, w_ld_major, w_ld_minor;
  logic [COORD_W-1:0]   w_x_nxt, w_y_nxt;
  logic signed [EW-1:0] w_major_s, w_minor_s, w_err_sub;

  logic [COORD_W-1:0]   r_x, r_y, r_major, r_minor, r_cnt;
  logic                 r_sx_neg, r_sy_neg, r_xmaj;
  logic signed [EW-1:0] r_err;

  assign w_dx       = $signed({1'b0, i_x1}) - $signed({1'b0, i_x0});
  assign w_dy       = $signed({1'b0, i_y1}) - $signed({1'b0, i_y0});
  assign w_adx      = w_dx[DW-1] ? COORD_W'(-w_dx) : COORD_W'(w_dx);
  assign w_ady      = w_dy[DW-1] ? COORD_W'(-w_dy) : COORD_W'(w_dy);
  assign w_ld_major = (w_adx > w_ady) ? w_adx : w_ady;
  assign w_ld_minor = (w_adx > w_ady) ? w_ady : w_adx;

  assign w_major_s  = $signed(EW'(r_major));
  assign w_minor_s  = $signed(EW'(r_minor));
  assign w_err_sub  = r_err - w_minor_s;
  assign w_x_nxt    = r_sx_neg ? r_x - COORD_W'(1) : r_x + COORD_W'(1);
  assign w_y_nxt    = r_sy_neg ? r_y - COORD_W'(1) : r_y + COORD_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_major  <= '0;
      r_minor  <= '0;
      r_cnt    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_xmaj   <= 1'b0;
      r_err    <= '0;
    end else if (i_load) begin
      r_x      <= i_x0;
      r_y      <= i_y0;
      r_sx_neg <= w_dx[DW-1];
      r_sy_neg <= w_dy[DW-1];
      r_xmaj   <= (w_adx > w_ady);
      r_major  <= w_ld_major;
      r_minor  <= w_ld_minor;
      r_err    <= $signed(EW'(w_ld_major >> 1));
      r_cnt    <= w_ld_major;
    end else if (i_step) begin
      // Major axis always moves; minor axis moves when the error goes negative.
      r_cnt <= r_cnt - COORD_W'(1);
      if (r_xmaj) r_x <= w_x_nxt;
      else        r_y <= w_y_nxt;
      if (w_err_sub[EW-1]) begin
        if (r_xmaj) r_y <= w_y_nxt;
        else        r_x <= w_x_nxt;
        r_err <= w_err_sub + w_major_s;
      end else begin
        r_err <= w_err_sub;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/line_cmd_scheduler.sv
// Round-robin line-command scheduler streaming Bresenham pixels to one sink.
// Define LINE_SCHED_ABORT_EN to add an ABORT input that cancels the line in progress.
module line_cmd_scheduler
  import line_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned COLOR_W = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [NUM_REQ-1:0]                     REQ_VALID,
  output logic [NUM_REQ-1:0]                     REQ_READY,
  input  logic [NUM_REQ*(4*COORD_W+COLOR_W)-1:0] REQ_CMD,
  output logic                                   PIX_VALID,
  input  logic                                   PIX_READY,
  output logic [COORD_W-1:0]                     PIX_X,
  output logic [COORD_W-1:0]                     PIX_Y,
  output logic [COLOR_W-1:0]                     PIX_COLOR,
  output logic                                   BUSY,
  output logic                                   DONE,
  output logic [$clog2(NUM_REQ)-1:0]             DONE_ID
`ifdef LINE_SCHED_ABORT_EN
  ,
  input  logic                                   ABORT
`endif
);
  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned CMD_W  = cmd_w(COORD_W, COLOR_W);
  localparam int unsigned OFF_X0 = field_off(FLD_X0, COORD_W, COLOR_W);
  localparam int unsigned OFF_Y0 = field_off(FLD_Y0, COORD_W, COLOR_W);
  localparam int unsigned OFF_X1 = field_off(FLD_X1, COORD_W, COLOR_W);
  localparam int unsigned OFF_Y1 = field_off(FLD_Y1, COORD_W, COLOR_W);

  state_t          r_state;
  logic [ID_W-1:0] r_last_grant, r_owner, r_done_id;
  logic [CMD_W-1:0] r_cmd;
  logic            r_pix_valid, r_busy, r_done;

  logic [ID_W-1:0]  w_gnt_id, w_idx;
  logic             w_gnt_any, w_fire, w_last, w_abort, w_load, w_step;
  logic [CMD_W-1:0] w_sel_cmd;

`ifdef LINE_SCHED_ABORT_EN
  assign w_abort = ABORT;
`else
  assign w_abort = 1'b0;
`endif

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    w_gnt_id  = '0;
    w_gnt_any = 1'b0;
    w_idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((32'(r_last_grant) + i) % NUM_REQ);
      if (!w_gnt_any && REQ_VALID[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_cmd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == ID_W'(i)) w_sel_cmd = REQ_CMD[i*CMD_W +: CMD_W];
    end
  end

  assign REQ_READY = (r_state == S_IDLE && !ARESET && w_gnt_any) ?
                     (NUM_REQ'(1) << w_gnt_id) : '0;
  assign w_fire    = r_pix_valid && PIX_READY;
  assign w_load    = (r_state == S_LOAD);
  assign w_step    = w_fire && !w_last;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_done_id    <= '0;
      r_cmd        <= '0;
      r_pix_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_gnt_any) begin
          r_cmd        <= w_sel_cmd;
          r_owner      <= w_gnt_id;
          r_last_grant <= w_gnt_id;
          r_busy       <= 1'b1;
          r_state      <= S_LOAD;
        end
        S_LOAD: begin
          if (w_abort) begin
            r_done    <= 1'b1;
            r_done_id <= r_owner;
            r_state   <= S_DONE;
          end else begin
            r_pix_valid <= 1'b1;
            r_state     <= S_DRAW;
          end
        end
        S_DRAW: if (w_abort || (w_fire && w_last)) begin
          r_pix_valid <= 1'b0;
          r_done      <= 1'b1;
          r_done_id   <= r_owner;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  line_stepper #(.COORD_W(COORD_W)) u_stepper (
    .i_clk  (ACLK),
    .i_rst  (ARESET),
    .i_load (w_load),
    .i_step (w_step),
    .i_x0   (r_cmd[OFF_X0 +: COORD_W]),
    .i_y0   (r_cmd[OFF_Y0 +: COORD_W]),
    .i_x1   (r_cmd[OFF_X1 +: COORD_W]),
    .i_y1   (r_cmd[OFF_Y1 +: COORD_W]),
    .o_x    (PIX_X),
    .o_y    (PIX_Y),
    .o_last (w_last)
  );

  assign PIX_VALID = r_pix_valid;
  assign PIX_COLOR = r_cmd[COLOR_W-1:0];
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign DONE_ID   = r_done_id;

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Directed self-checking bench for line_cmd_scheduler (default parameters).
module tb_line_cmd_scheduler;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned CMD_W   = 4 * COORD_W + COLOR_W;

  logic                     ACLK = 1'b0;
  logic                     ARESET;
  logic [NUM_REQ-1:0]       REQ_VALID, REQ_READY;
  logic [NUM_REQ*CMD_W-1:0] REQ_CMD;
  logic                     PIX_VALID, PIX_READY;
  logic [COORD_W-1:0]       PIX_X, PIX_Y;
  logic [COLOR_W-1:0]       PIX_COLOR;
  logic                     BUSY, DONE;
  logic [0:0]               DONE_ID;
`ifdef LINE_SCHED_ABORT_EN
  logic                     ABORT;
`endif

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  line_cmd_scheduler #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W), .COLOR_W(COLOR_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_CMD(REQ_CMD), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_X(PIX_X),
    .PIX_Y(PIX_Y), .PIX_COLOR(PIX_COLOR), .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID)
`ifdef LINE_SCHED_ABORT_EN
    , .ABORT(ABORT)
`endif
  );

  function automatic logic [CMD_W-1:0] mk(input int x0, input int y0, input int x1,
                                          input int y1, input int c);
    return {8'(x0), 8'(y0), 8'(x1), 8'(y1), 4'(c)};
  endfunction

  task automatic set_cmd(input int r, input logic [CMD_W-1:0] c);
    REQ_CMD[r*CMD_W +: CMD_W] = c;
  endtask

  task automatic next_cycle;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESET    = 1'b1;
    REQ_VALID = 2'b11;
    REQ_CMD   = '0;
    PIX_READY = 1'b1;
`ifdef LINE_SCHED_ABORT_EN
    ABORT = 1'b0;
`endif
    repeat (2) next_cycle();
    total++; if (REQ_READY !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", REQ_READY); end
    total++; if (PIX_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=v%b b%b d%b exp=000", PIX_VALID, BUSY, DONE); end
    total++; if (PIX_X !== 8'd0 || PIX_Y !== 8'd0 || PIX_COLOR !== 4'd0 || DONE_ID !== 1'b0) begin
      bad++; $display("FAIL rst_data got=%0d,%0d,%0d,%0d exp=0", PIX_X, PIX_Y, PIX_COLOR, DONE_ID); end
    REQ_VALID = 2'b00;
    ARESET    = 1'b0;
    next_cycle();
  endtask

  task automatic test_round_robin;
    int w;
    logic [1:0] exp_g;
    set_cmd(0, mk(1, 1, 1, 1, 1));
    set_cmd(1, mk(2, 2, 2, 2, 2));
    REQ_VALID = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      while (REQ_READY === 2'b00 && w < 10) begin next_cycle(); w++; end
      total++; if (REQ_READY !== exp_g) begin
        bad++; $display("FAIL rr_grant g=%0d got=%b exp=%b", g, REQ_READY, exp_g); end
      next_cycle();
      total++; if (REQ_READY !== 2'b00) begin
        bad++; $display("FAIL rr_one_cycle g=%0d got=%b exp=00", g, REQ_READY); end
      w = 0;
      while (DONE !== 1'b1 && w < 10) begin next_cycle(); w++; end
      if (g == 3) REQ_VALID = 2'b00;
      total++; if (DONE !== 1'b1 || DONE_ID !== 1'(g % 2)) begin
        bad++; $display("FAIL rr_done g=%0d got=%b/%0d exp=1/%0d", g, DONE, DONE_ID, g % 2); end
    end
    next_cycle();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", BUSY); end
  endtask

  task automatic test_basic;
    int ex[4] = '{10, 11, 12, 13};
    int ey[4] = '{10, 10, 11, 11};
    set_cmd(0, mk(10, 10, 13, 11, 7));
    REQ_VALID = 2'b01;
    #1;
    total++; if (REQ_READY !== 2'b01) begin bad++; $display("FAIL basic_accept got=%b exp=01", REQ_READY); end
    next_cycle();
    total++; if (BUSY !== 1'b1 || PIX_VALID !== 1'b0 || REQ_READY !== 2'b00) begin
      bad++; $display("FAIL basic_load got=b%b v%b r%b exp=b1 v0 r00", BUSY, PIX_VALID, REQ_READY); end
    REQ_VALID = 2'b00;
    set_cmd(0, mk(99, 99, 0, 0, 15));
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      total++; if (PIX_VALID !== 1'b1 || PIX_X !== 8'(ex[k]) || PIX_Y !== 8'(ey[k]) || PIX_COLOR !== 4'd7) begin
        bad++; $display("FAIL basic_pix k=%0d got=v%b (%0d,%0d) c%0d exp=v1 (%0d,%0d) c7",
                        k, PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, ex[k], ey[k]); end
    end
    next_cycle();
    total++; if (DONE !== 1'b1 || DONE_ID !== 1'b0 || PIX_VALID !== 1'b0) begin
      bad++; $display("FAIL basic_done got=d%b id%0d v%b exp=d1 id0 v0", DONE, DONE_ID, PIX_VALID); end
    next_cycle();
    total++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL basic_idle got=d%b b%b exp=d0 b0", DONE, BUSY); end
  endtask

  task automatic test_point;
    set_cmd(1, mk(5, 5, 5, 5, 3));
    REQ_VALID = 2'b10;
    #1;
    total++; if (REQ_READY !== 2'b10) begin bad++; $display("FAIL point_accept got=%b exp=10", REQ_READY); end
    next_cycle();
    REQ_VALID = 2'b00;
    next_cycle();
    total++; if (PIX_VALID !== 1'b1 || PIX_X !== 8'd5 || PIX_Y !== 8'd5 || PIX_COLOR !== 4'd3) begin
      bad++; $display("FAIL point_pix got=v%b (%0d,%0d) c%0d exp=v1 (5,5) c3", PIX_VALID, PIX_X, PIX_Y, PIX_COLOR); end
    next_cycle();
    total++; if (DONE !== 1'b1 || DONE_ID !== 1'b1 || PIX_VALID !== 1'b0) begin
      bad++; $display("FAIL point_done got=d%b id%0d v%b exp=d1 id1 v0", DONE, DONE_ID, PIX_VALID); end
    next_cycle();
  endtask

  task automatic test_long;
    int cnt = 0;
    int w = 0;
    bit got_done = 1'b0;
    set_cmd(0, mk(255, 0, 0, 255, 12));
    REQ_VALID = 2'b01;
    next_cycle();
    REQ_VALID = 2'b00;
    while (!got_done && w < 300) begin
      next_cycle();
      w++;
      if (DONE === 1'b1) got_done = 1'b1;
      else if (PIX_VALID === 1'b1) begin
        total++; if (PIX_X !== 8'(255 - cnt) || PIX_Y !== 8'(cnt)) begin
          bad++; $display("FAIL long_pix n=%0d got=(%0d,%0d) exp=(%0d,%0d)", cnt, PIX_X, PIX_Y, 255 - cnt, cnt); end
        cnt++;
      end
    end
    total++; if (!got_done || cnt != 256) begin
      bad++; $display("FAIL long_count got=%0d done=%b exp=256 done=1", cnt, got_done); end
    next_cycle();
  endtask

  task automatic test_stall;
    int ex[4] = '{0, 1, 2, 3};
    int ey[4] = '{0, 1, 1, 2};
    bit pat[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int idx = 0;
    set_cmd(1, mk(0, 0, 3, 2, 9));
    REQ_VALID = 2'b10;
    next_cycle();
    REQ_VALID = 2'b00;
    for (int c = 0; c < 8 && idx < 4; c++) begin
      next_cycle();
      total++; if (PIX_VALID !== 1'b1 || PIX_X !== 8'(ex[idx]) || PIX_Y !== 8'(ey[idx]) || PIX_COLOR !== 4'd9) begin
        bad++; $display("FAIL stall_pix c=%0d got=v%b (%0d,%0d) exp=v1 (%0d,%0d)",
                        c, PIX_VALID, PIX_X, PIX_Y, ex[idx], ey[idx]); end
      PIX_READY = pat[c];
      if (pat[c]) idx++;
    end
    PIX_READY = 1'b1;
    next_cycle();
    total++; if (idx != 4 || DONE !== 1'b1 || DONE_ID !== 1'b1) begin
      bad++; $display("FAIL stall_done got=n%0d d%b id%0d exp=n4 d1 id1", idx, DONE, DONE_ID); end
    next_cycle();
  endtask

  task automatic test_reset_mid;
    int w = 0;
    bit saw_done = 1'b0;
    set_cmd(0, mk(0, 0, 20, 0, 5));
    REQ_VALID = 2'b01;
    next_cycle();
    REQ_VALID = 2'b00;
    repeat (3) next_cycle();
    #2;
    ARESET = 1'b1;
    #1;
    total++; if (PIX_VALID !== 1'b0 || BUSY !== 1'b0 || PIX_X !== 8'd0 || PIX_COLOR !== 4'd0 || DONE !== 1'b0) begin
      bad++; $display("FAIL midrst_out got=v%b b%b x%0d c%0d d%b exp=0", PIX_VALID, BUSY, PIX_X, PIX_COLOR, DONE); end
    next_cycle();
    ARESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (DONE !== 1'b0 || BUSY !== 1'b0) saw_done = 1'b1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL midrst_quiet got=activity exp=idle"); end
    set_cmd(0, mk(4, 4, 4, 4, 1));
    set_cmd(1, mk(6, 6, 6, 6, 2));
    REQ_VALID = 2'b11;
    #1;
    total++; if (REQ_READY !== 2'b01) begin bad++; $display("FAIL midrst_grant got=%b exp=01", REQ_READY); end
    next_cycle();
    REQ_VALID = 2'b00;
    while (DONE !== 1'b1 && w < 10) begin next_cycle(); w++; end
    total++; if (DONE !== 1'b1 || DONE_ID !== 1'b0) begin
      bad++; $display("FAIL midrst_line got=d%b id%0d exp=d1 id0", DONE, DONE_ID); end
    next_cycle();
  endtask

`ifdef LINE_SCHED_ABORT_EN
  task automatic test_abort;
    int dones = 0;
    set_cmd(1, mk(0, 0, 30, 0, 4));
    REQ_VALID = 2'b10;
    next_cycle();
    REQ_VALID = 2'b00;
    repeat (3) next_cycle();
    ABORT = 1'b1;
    next_cycle();
    ABORT = 1'b0;
    total++; if (PIX_VALID !== 1'b0 || DONE !== 1'b1 || DONE_ID !== 1'b1) begin
      bad++; $display("FAIL abort_done got=v%b d%b id%0d exp=v0 d1 id1", PIX_VALID, DONE, DONE_ID); end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (DONE === 1'b1) dones++;
    end
    total++; if (dones != 0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL abort_once got=extra%0d b%b exp=0 b0", dones, BUSY); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_point();
    test_long();
    test_stall();
    test_reset_mid();
`ifdef LINE_SCHED_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
